// File: rtl/servant_pkg.sv
// ----------------------------------------------------------------------------
// servant_pkg
//   Shared definitions for the servant peripherals.
//   - intc_reg_e : word offsets of the interrupt controller registers,
//                  selected by bus address bits [3:2].
//   - MAX_SRC    : largest number of interrupt sources the controller allows.
//   - ACTIVE_W   : width of the ACTIVE field (index+1 of up to 31 sources).
// ----------------------------------------------------------------------------
package servant_pkg;

   typedef enum logic [1:0] {
      INTC_PENDING = 2'd0,
      INTC_ENABLE  = 2'd1,
      INTC_TYPE    = 2'd2,
      INTC_ACTIVE  = 2'd3
   } intc_reg_e;

   localparam int unsigned MAX_SRC  = 31;
   localparam int unsigned ACTIVE_W = 5;

endpackage

// File: rtl/servant_intc_sync.sv
// ----------------------------------------------------------------------------
// servant_intc_sync
//   Vector flop-chain synchroniser for the interrupt source lines.
//   Each bit is passed through STAGES flops clocked by i_clk. With STAGES=0
//   the module is a plain wire, for sources that already live in i_clk.
//   RESET_STRATEGY="NONE" builds the chain without reset.
// Ports
//   i_clk  in  1      system clock
//   i_rst  in  1      synchronous, active-high reset
//   i_d    in  WIDTH  raw (possibly asynchronous) lines
//   o_q    out WIDTH  lines synchronised to i_clk
// ----------------------------------------------------------------------------
module servant_intc_sync #(
   parameter int unsigned WIDTH          = 4,
   parameter int unsigned STAGES         = 2,
   parameter string       RESET_STRATEGY = ""
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = i_clk ^ i_rst;
      assign o_q = i_d;
   end else begin : g_chain
      logic [WIDTH-1:0] sync_q [STAGES];

      if (RESET_STRATEGY == "NONE") begin : g_no_rst
         logic unused_rst;
         assign unused_rst = i_rst;
         always_ff @(posedge i_clk) begin
            sync_q[0] <= i_d;
            for (int unsigned k = 1; k < STAGES; k++) begin
               sync_q[k] <= sync_q[k-1];
            end
         end
      end else begin : g_rst
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int unsigned k = 0; k < STAGES; k++) begin
                  sync_q[k] <= '0;
               end
            end else begin
               sync_q[0] <= i_d;
               for (int unsigned k = 1; k < STAGES; k++) begin
                  sync_q[k] <= sync_q[k-1];
               end
            end
         end
      end

      assign o_q = sync_q[STAGES-1];
   end

endmodule

// File: rtl/servant_intc.sv
// ----------------------------------------------------------------------------
// servant_intc
//   Interrupt controller between the timer IRQ (plus other peripheral IRQ
//   lines) and the CPU timer-interrupt input. Sources are synchronised,
//   latched as edge- or level-type pending bits, masked by ENABLE and
//   combined into one registered interrupt. The bus slot never acks; the
//   servant mux does that.
//
//   Register map (word index = bus address [3:2]):
//     0 PENDING  R / W1C (W1C ignored for level sources)
//     1 ENABLE   RW
//     2 TYPE     RW, 1 = edge, 0 = level
//     3 ACTIVE   RO, index+1 of lowest pending&enabled source, 0 if none
//   Bits >= NUM_SRC read 0 and are ignored on write.
//
// Ports
//   i_clk     in  1        system clock, the only clock
//   i_rst     in  1        synchronous, active-high reset
//   i_src     in  NUM_SRC  raw interrupt lines (may be asynchronous)
//   i_wb_adr  in  2        word select
//   i_wb_dat  in  32       write data
//   i_wb_we   in  1        write enable
//   i_wb_cyc  in  1        cycle valid
//   o_wb_dat  out 32       read data, combinational from i_wb_adr
//   o_irq     out 1        interrupt to CPU
// ----------------------------------------------------------------------------
module servant_intc
   import servant_pkg::*;
#(
   parameter int unsigned NUM_SRC        = 4,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter string       RESET_STRATEGY = ""
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_SRC-1:0] i_src,
   input  logic [1:0]         i_wb_adr,
   input  logic [31:0]        i_wb_dat,
   input  logic               i_wb_we,
   input  logic               i_wb_cyc,
   output logic [31:0]        o_wb_dat,
   output logic               o_irq
);

   logic [NUM_SRC-1:0]  src_s;
   logic [NUM_SRC-1:0]  prev_q;
   logic [NUM_SRC-1:0]  pend_q, pend_d;
   logic [NUM_SRC-1:0]  en_q, en_d;
   logic [NUM_SRC-1:0]  type_q, type_d;
   logic [NUM_SRC-1:0]  w1c;
   logic [NUM_SRC-1:0]  hits;
   logic                irq_q, irq_d;
   logic [ACTIVE_W-1:0] active;
   logic                wr_en;
   intc_reg_e           reg_sel;

   // Upper write-data bits have no register behind them.
   logic unused_wb_dat;
   assign unused_wb_dat = ^i_wb_dat[31:NUM_SRC];

   servant_intc_sync #(
      .WIDTH          (NUM_SRC),
      .STAGES         (SYNC_STAGES),
      .RESET_STRATEGY (RESET_STRATEGY)
   ) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_src),
      .o_q   (src_s)
   );

   // Edge-history flop; follows the synchroniser's reset strategy so that a
   // line held high through reset reads as a fresh edge only if prev resets.
   if (RESET_STRATEGY == "NONE") begin : g_prev_no_rst
      always_ff @(posedge i_clk) begin
         prev_q <= src_s;
      end
   end else begin : g_prev_rst
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            prev_q <= '0;
         end else begin
            prev_q <= src_s;
         end
      end
   end

   assign wr_en   = i_wb_cyc & i_wb_we;
   assign reg_sel = intc_reg_e'(i_wb_adr);

   // Register write decode
   always_comb begin
      en_d   = en_q;
      type_d = type_q;
      w1c    = '0;
      if (wr_en) begin
         unique case (reg_sel)
            INTC_PENDING: w1c    = i_wb_dat[NUM_SRC-1:0];
            INTC_ENABLE:  en_d   = i_wb_dat[NUM_SRC-1:0];
            INTC_TYPE:    type_d = i_wb_dat[NUM_SRC-1:0];
            INTC_ACTIVE:  ;
         endcase
      end
   end

   // Edge bits hold until cleared; a new rising edge beats a same-cycle
   // clear. Level bits simply track the synchronised line.
   assign pend_d = (type_q & ((pend_q & ~w1c) | (src_s & ~prev_q)))
                 | (~type_q & src_s);

   assign hits  = pend_q & en_q;
   assign irq_d = |hits;

   // Scan from the top down so the lowest-numbered hit is written last.
   always_comb begin
      active = '0;
      for (int unsigned i = NUM_SRC; i > 0; i--) begin
         if (hits[i-1]) begin
            active = ACTIVE_W'(i);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pend_q <= '0;
         en_q   <= '0;
         type_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         en_q   <= en_d;
         type_q <= type_d;
         irq_q  <= irq_d;
      end
   end

   // Read mux
   always_comb begin
      o_wb_dat = '0;
      unique case (reg_sel)
         INTC_PENDING: o_wb_dat[NUM_SRC-1:0]  = pend_q;
         INTC_ENABLE:  o_wb_dat[NUM_SRC-1:0]  = en_q;
         INTC_TYPE:    o_wb_dat[NUM_SRC-1:0]  = type_q;
         INTC_ACTIVE:  o_wb_dat[ACTIVE_W-1:0] = active;
      endcase
   end

   assign o_irq = irq_q;

endmodule
